// File: rtl/cl_cfg_reg_slv_pkg.sv
// ----------------------------------------------------------------------------
// cl_cfg_reg_slv_pkg
// Shared types and constants for the cfg bus responder cl_cfg_reg_slv.
//   state_t         : responder FSM states (IDLE, WAIT, ACK)
//   OFS_*           : byte offsets of the registers inside the 256B window
//   UNMAPPED_RDATA  : value returned for reads of offsets with no register
// ----------------------------------------------------------------------------
package cl_cfg_reg_slv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic [7:0] OFS_CTRL    = 8'h00;
    localparam logic [7:0] OFS_STATUS  = 8'h04;
    localparam logic [7:0] OFS_SCRATCH = 8'h08;
    localparam logic [7:0] OFS_WR_CNT  = 8'h0C;
    localparam logic [7:0] OFS_RD_CNT  = 8'h10;
    localparam logic [7:0] OFS_ERR_CNT = 8'h14;
    localparam logic [7:0] OFS_ID      = 8'h18;

    localparam logic [31:0] UNMAPPED_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/cl_cfg_reg_slv.sv
// ----------------------------------------------------------------------------
// cl_cfg_reg_slv
// Responder end of the cfg bus. Accepts 1-cycle wr/rd pulses, answers each
// accepted request with a 1-cycle cfg_ack ACK_LAT clock edges after the edge
// that accepted it, and hosts a small register file (CTRL, STATUS, SCRATCH,
// write/read access counters, ID) for one 256B window.
//
// Optional feature: define CFG_REG_SLV_ERR_CNT_EN to add a saturating ERR_CNT
// register at 0x14 counting dropped requests; otherwise 0x14 is unmapped.
//
// Ports
//   clk         in   1   clock
//   sync_rst_n  in   1   asynchronous active-low reset
//   cfg_addr    in   32  byte address, only [7:2] decoded
//   cfg_wdata   in   32  write data, valid with cfg_wr
//   cfg_wr      in   1   write request pulse
//   cfg_rd      in   1   read request pulse
//   cfg_ack     out  1   completion pulse
//   cfg_rdata   out  32  read data, valid with cfg_ack, held until next read ack
//   ctrl_o      out  32  CTRL contents, bit0 always 0
//   start_o     out  1   pulse with the ack of a CTRL write carrying bit0=1
//   status_i    in   32  live status, sampled when read data is captured
// ----------------------------------------------------------------------------
module cl_cfg_reg_slv
    import cl_cfg_reg_slv_pkg::*;
#(
    parameter int unsigned  ACK_LAT  = 2,
    parameter logic [31:0]  ID_VALUE = 32'hC0DE_0001,
    parameter logic [31:0]  CTRL_RST = 32'h0
) (
    input  logic        clk,
    input  logic        sync_rst_n,
    input  logic [31:0] cfg_addr,
    input  logic [31:0] cfg_wdata,
    input  logic        cfg_wr,
    input  logic        cfg_rd,
    output logic        cfg_ack,
    output logic [31:0] cfg_rdata,
    output logic [31:0] ctrl_o,
    output logic        start_o,
    input  logic [31:0] status_i
);

    localparam logic [3:0] LAT_LOAD = 4'(ACK_LAT - 1);

    state_t      state_q, state_d;
    logic [3:0]  lat_q, lat_d;
    logic        accept;
    logic        commit;

    logic [5:0]  addr_q;
    logic [31:0] wdata_q;
    logic        is_wr_q;
    logic [7:0]  ofs;

    logic [31:1] ctrl_hi_q;
    logic [31:0] scratch_q;
    logic [31:0] wr_cnt_q;
    logic [31:0] rd_cnt_q;
    logic [31:0] rd_val;

    // Address bits outside [7:2] are deliberately ignored.
    logic        unused_addr_bits;
    assign unused_addr_bits = ^{cfg_addr[31:8], cfg_addr[1:0]};

    assign ofs     = {addr_q, 2'b00};
    assign cfg_ack = (state_q == ACK);
    assign ctrl_o  = {ctrl_hi_q, 1'b0};

    always_ff @(posedge clk or negedge sync_rst_n) begin
        if (!sync_rst_n) begin
            state_q <= IDLE;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
        end
    end

    // WAIT lasts ACK_LAT cycles (lat counts LAT_LOAD down to 0), so the ack
    // rises on the ACK_LAT-th edge after the accepting edge.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_wr || cfg_rd) begin
                    state_d = WAIT;
                    lat_d   = LAT_LOAD;
                    accept  = 1'b1;
                end
            end
            WAIT: begin
                if (lat_q == 4'd0) begin
                    state_d = ACK;
                    commit  = 1'b1;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef CFG_REG_SLV_ERR_CNT_EN
    logic [31:0] err_cnt_q;
    logic        drop;
    logic        err_clr;

    // A dropped request is any pulse while busy, or the read half of a
    // simultaneous wr+rd in IDLE.
    assign drop    = ((state_q != IDLE) && (cfg_wr || cfg_rd)) ||
                     ((state_q == IDLE) && cfg_wr && cfg_rd);
    assign err_clr = commit && is_wr_q && (ofs == OFS_ERR_CNT);

    always_ff @(posedge clk or negedge sync_rst_n) begin
        if (!sync_rst_n) begin
            err_cnt_q <= '0;
        end else if (err_clr) begin
            err_cnt_q <= {31'd0, drop};
        end else if (drop && (err_cnt_q != 32'hFFFF_FFFF)) begin
            err_cnt_q <= err_cnt_q + 32'd1;
        end
    end
`endif

    always_comb begin
        rd_val = UNMAPPED_RDATA;
        case (ofs)
            OFS_CTRL:    rd_val = {ctrl_hi_q, 1'b0};
            OFS_STATUS:  rd_val = status_i;
            OFS_SCRATCH: rd_val = scratch_q;
            OFS_WR_CNT:  rd_val = wr_cnt_q;
            OFS_RD_CNT:  rd_val = rd_cnt_q;
`ifdef CFG_REG_SLV_ERR_CNT_EN
            OFS_ERR_CNT: rd_val = err_cnt_q;
`endif
            OFS_ID:      rd_val = ID_VALUE;
            default:     rd_val = UNMAPPED_RDATA;
        endcase
    end

    // Request latch and access counters; a simultaneous wr+rd is a write.
    always_ff @(posedge clk or negedge sync_rst_n) begin
        if (!sync_rst_n) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            is_wr_q  <= 1'b0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else if (accept) begin
            addr_q  <= cfg_addr[7:2];
            wdata_q <= cfg_wdata;
            is_wr_q <= cfg_wr;
            if (cfg_wr) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end else begin
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end
        end
    end

    // Write commit / read capture on the WAIT->ACK edge so both are visible
    // in the ack cycle.
    always_ff @(posedge clk or negedge sync_rst_n) begin
        if (!sync_rst_n) begin
            ctrl_hi_q <= CTRL_RST[31:1];
            scratch_q <= '0;
            cfg_rdata <= '0;
            start_o   <= 1'b0;
        end else begin
            start_o <= 1'b0;
            if (commit) begin
                if (is_wr_q) begin
                    if (ofs == OFS_CTRL) begin
                        ctrl_hi_q <= wdata_q[31:1];
                        start_o   <= wdata_q[0];
                    end
                    if (ofs == OFS_SCRATCH) begin
                        scratch_q <= wdata_q;
                    end
                end else begin
                    cfg_rdata <= rd_val;
                end
            end
        end
    end

endmodule

// File: tb/tb_cl_cfg_reg_slv.sv
// ----------------------------------------------------------------------------
// tb_cl_cfg_reg_slv
// Directed self-checking bench for cl_cfg_reg_slv with ACK_LAT=2.
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_cl_cfg_reg_slv;

    localparam logic [31:0] ID_VAL   = 32'hC0DE_0001;
    localparam logic [31:0] CTRL_RV  = 32'hA5A5_0003;
    localparam int          LAT      = 2;

    logic        clk;
    logic        sync_rst_n;
    logic [31:0] cfg_addr;
    logic [31:0] cfg_wdata;
    logic        cfg_wr;
    logic        cfg_rd;
    logic        cfg_ack;
    logic [31:0] cfg_rdata;
    logic [31:0] ctrl_o;
    logic        start_o;
    logic [31:0] status_i;

    int checks = 0;
    int errors = 0;
    int exp_wr = 0;
    int exp_rd = 0;

    cl_cfg_reg_slv #(
        .ACK_LAT  (LAT),
        .ID_VALUE (ID_VAL),
        .CTRL_RST (CTRL_RV)
    ) dut (
        .clk        (clk),
        .sync_rst_n (sync_rst_n),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_wr     (cfg_wr),
        .cfg_rd     (cfg_rd),
        .cfg_ack    (cfg_ack),
        .cfg_rdata  (cfg_rdata),
        .ctrl_o     (ctrl_o),
        .start_o    (start_o),
        .status_i   (status_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request pulse; waits (bounded) for the ack and returns what was
    // seen in the ack cycle. lat = edges after the accepting edge, -1 if none.
    task automatic applyStimulus(input logic wr, input logic rd, input logic [31:0] addr,
                                 input logic [31:0] wdata, output logic [31:0] rdata,
                                 output logic start_seen, output int lat);
        int n;
        @(negedge clk);
        cfg_wr = wr; cfg_rd = rd; cfg_addr = addr; cfg_wdata = wdata;
        @(negedge clk);
        cfg_wr = 1'b0; cfg_rd = 1'b0;
        n = 1;
        while (!cfg_ack && n < 40) begin
            @(negedge clk);
            n++;
        end
        lat        = cfg_ack ? n - 1 : -1;
        rdata      = cfg_rdata;
        start_seen = start_o;
        if (wr)      exp_wr++;
        else if (rd) exp_rd++;
    endtask

    task automatic doWrite(input string tag, input logic [31:0] addr, input logic [31:0] data,
                           input logic exp_start);
        logic [31:0] rdata; logic st; int lat;
        applyStimulus(1'b1, 1'b0, addr, data, rdata, st, lat);
        checkOutput({tag, " lat"}, 32'(lat), 32'(LAT));
        checkOutput({tag, " start"}, {31'd0, st}, {31'd0, exp_start});
    endtask

    task automatic doRead(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rdata; logic st; int lat;
        applyStimulus(1'b0, 1'b1, addr, 32'h0, rdata, st, lat);
        checkOutput({tag, " lat"}, 32'(lat), 32'(LAT));
        checkOutput({tag, " rdata"}, rdata, exp);
    endtask

    task automatic countAcks(input int cycles, output int acks);
        acks = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (cfg_ack) acks++;
        end
    endtask

    logic [31:0] rd_tmp;
    logic        st_tmp;
    int          lat_tmp;
    int          acks;

    initial begin
        sync_rst_n = 1'b0;
        cfg_addr = '0; cfg_wdata = '0; cfg_wr = 1'b0; cfg_rd = 1'b0;
        status_i = 32'h5A5A_1234;
        repeat (3) @(negedge clk);
        checkOutput("rst ack",   {31'd0, cfg_ack}, 32'd0);
        checkOutput("rst rdata", cfg_rdata, 32'd0);
        checkOutput("rst ctrl",  ctrl_o, 32'hA5A5_0002);
        checkOutput("rst start", {31'd0, start_o}, 32'd0);
        sync_rst_n = 1'b1;
        @(negedge clk);

        // SCRATCH write/read, plus ack is a single cycle
        doWrite("wr scratch", 32'h08, 32'h1234_5678, 1'b0);
        @(negedge clk);
        checkOutput("ack width", {31'd0, cfg_ack}, 32'd0);
        doRead("rd scratch", 32'h08, 32'h1234_5678);

        // CTRL: bit0 pulses start, reads back 0
        applyStimulus(1'b1, 1'b0, 32'h00, 32'h0000_00F1, rd_tmp, st_tmp, lat_tmp);
        checkOutput("wr ctrl lat",   32'(lat_tmp), 32'(LAT));
        checkOutput("wr ctrl start", {31'd0, st_tmp}, 32'd1);
        checkOutput("wr ctrl ctrl_o", ctrl_o, 32'h0000_00F0);
        @(negedge clk);
        checkOutput("start width", {31'd0, start_o}, 32'd0);
        doRead("rd ctrl", 32'h00, 32'h0000_00F0);

        doRead("rd unmapped", 32'h40, 32'hDEAD_BEEF);
        doRead("rd id", 32'h18, ID_VAL);
        doWrite("wr id", 32'h18, 32'h0, 1'b0);
        doRead("rd id again", 32'h18, ID_VAL);
        doRead("rd status", 32'h04, 32'h5A5A_1234);

        // counters include the current access's own increment
        doRead("rd wr_cnt", 32'h0C, 32'(exp_wr));
        doRead("rd rd_cnt", 32'h10, 32'(exp_rd + 1));

        // second read pulse while busy is dropped
        @(negedge clk);
        cfg_rd = 1'b1; cfg_addr = 32'h08;
        @(negedge clk);
        cfg_rd = 1'b1;
        @(negedge clk);
        cfg_rd = 1'b0;
        exp_rd++;
        countAcks(10, acks);
        checkOutput("busy drop acks", 32'(acks), 32'd1);
`ifdef CFG_REG_SLV_ERR_CNT_EN
        doRead("rd err_cnt 1", 32'h14, 32'd1);
`else
        doRead("rd 0x14", 32'h14, 32'hDEAD_BEEF);
`endif

        // simultaneous wr+rd is a write only
        applyStimulus(1'b1, 1'b1, 32'h08, 32'hCAFE_0000, rd_tmp, st_tmp, lat_tmp);
        checkOutput("wr+rd lat", 32'(lat_tmp), 32'(LAT));
        doRead("wr+rd scratch", 32'h08, 32'hCAFE_0000);
        doRead("wr+rd wr_cnt", 32'h0C, 32'(exp_wr));
`ifdef CFG_REG_SLV_ERR_CNT_EN
        doRead("rd err_cnt 2", 32'h14, 32'd2);
        doWrite("clr err_cnt", 32'h14, 32'h1234, 1'b0);
        doRead("rd err_cnt 0", 32'h14, 32'd0);
`endif

        // reset while a CTRL write is in WAIT
        @(negedge clk);
        cfg_wr = 1'b1; cfg_addr = 32'h00; cfg_wdata = 32'h0000_0F01;
        @(negedge clk);
        cfg_wr = 1'b0;
        sync_rst_n = 1'b0;
        countAcks(3, acks);
        sync_rst_n = 1'b1;
        exp_wr = 0; exp_rd = 0;
        begin
            int more;
            countAcks(5, more);
            checkOutput("rst mid acks", 32'(acks + more), 32'd0);
        end
        checkOutput("rst mid ctrl",  ctrl_o, 32'hA5A5_0002);
        checkOutput("rst mid start", {31'd0, start_o}, 32'd0);
        doRead("rst mid scratch", 32'h08, 32'd0);
        doRead("rst mid wr_cnt", 32'h0C, 32'd0);
        doRead("rst mid rd_cnt", 32'h10, 32'd3);

        $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
